motor_drive_sequencer: RTL and testbench
========================================

# motor_drive_sequencer

Command-driven sequencer for the robot's two L298N H-bridge drivers (drv1 = left side motors A/B, drv2 = right side motors A/B). Accepts drive commands (op, speed, duration) over a valid/ready handshake, produces PWM on all four enable pins, and sets the direction pins. Enforces a coast dead-time on any direction reversal, and stops on duration expiry or emergency stop. Sits between the high-level control logic and the motor pins, replacing the constant pin drive.

## Interface
Parameters:
- PWM_BITS, 8: PWM counter and speed width.
- TICK_DIV, 1000: clocks per duration tick (≥2).
- DEAD_TICKS, 50: coast ticks inserted on a direction reversal (≥1).

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- e_stop  in  1  level, synchronous to clk; forces stop while high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  0 STOP, 1 FWD, 2 REV, 3 TURN_L, 4 TURN_R; 5-7 treated as STOP.
- cmd_speed  in  PWM_BITS  duty value.
- cmd_duration  in  16  run length in ticks; 0 = run until the next command.
- busy  out  1  high in RUN or COAST.
- done  out  1  one-cycle pulse when a timed command expires.
- drv1_motor_a_en, drv1_motor_b_en, drv2_motor_a_en, drv2_motor_b_en  out  1 each  PWM enables.
- drv1_motor_a_in1/in2, drv1_motor_b_in3/in4, drv2_motor_a_in1/in2, drv2_motor_b_in3/in4  out  1 each  direction pins.

## Operation
- Side direction encoding: FWD gives in1/in3=1, in2/in4=0. REV gives 0/1. OFF gives 0/0 with en=0.
- Op mapping (left, right): FWD = (FWD, FWD). REV = (REV, REV). TURN_L = (REV, FWD). TURN_R = (FWD, REV). STOP = (OFF, OFF).
- PWM: free-running counter, 0 to 2^PWM_BITS−1. Each en = active_side && (pwm_cnt < speed_reg). Speed 0 means en is constantly 0; 255 gives 255/256 duty.
- FSM states:
  - IDLE: all outputs off; cmd_ready=1.
    - Accepting a non-STOP command with speed ≠ 0 loads the registers and goes to RUN.
    - Accepting STOP, or any command with speed 0, stays in IDLE.
  - RUN: cmd_ready=1, so a new command preempts the running one.
    - If the new command reverses either side (FWD↔REV), load a pending command and go to COAST.
    - Otherwise apply the new command at once and restart its duration.
    - STOP goes to IDLE.
    - When the duration counter reaches 0 on a timed command: go to IDLE and pulse done.
  - COAST: all pins 0/0, en=0, cmd_ready=0. After DEAD_TICKS ticks, go to RUN with the pending command.
- Accepting a command resets the tick prescaler to 0.
- Duration counts down one per tick. The command ends exactly cmd_duration ticks after acceptance.
- e_stop high: go to IDLE next cycle from any state and drop any pending command; cmd_ready=0; no done pulse. On e_stop release, stay in IDLE.
- Simultaneous e_stop and a valid command: e_stop wins; the command is not accepted.
- A command accepted in the same cycle as expiry wins over expiry; no done pulse.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, all en=0, all in pins 0. PWM counter, prescaler and duration counter at 0.
- All outputs are registered. A command accepted at edge N shows on the pins after edge N+1. Same-direction preemption also takes effect after edge N+1.
- COAST lasts DEAD_TICKS×TICK_DIV clocks from the acceptance edge.
- done asserts in the cycle after the pins go off.
- Asynchronous reset mid-operation: all outputs reach their reset values immediately, with no glitch to any active drive.

## Structure
- Package motor_pkg holds:
  - the op enum;
  - the FSM state enum {IDLE, RUN, COAST};
  - the side direction enum {OFF, FWD, REV} with its 2-bit pin encoding;
  - an op→(left, right) mapping function.
- Sub-module motor_pwm: PWM counter and comparator, instanced once. It outputs pwm_cnt or the compare result for the shared speed.

## Test plan
Run the bench with TICK_DIV=4 and DEAD_TICKS=2.
- Reset, then FWD at speed 128 for duration 3: all in1/in3=1, in2/in4=0; each en is high for 128 of every 256 clocks. After 12 clocks the pins go to 0, done pulses once, and busy falls.
- FWD running, then REV accepted: 8 clocks of all-zero pins with cmd_ready=0, then in pattern 0/1, with 20 ticks counted from the REV acceptance.
- FWD running, then FWD at speed 255 accepted: no COAST, duty 255/256 next cycle, duration restarted.
- TURN_L at speed 64, duration 0: drv1 pins 0/1, drv2 pins 1/0. The command holds for more than 1000 clocks with no done pulse. A STOP then turns everything off after 1 clock.
- e_stop raised during COAST, together with a valid command: the command is not accepted, IDLE is reached next cycle, and no done pulse occurs. After release, cmd_ready=1.
- cmd_op=6 or cmd_speed=0 while IDLE: accepted, outputs stay off, busy stays 0.

Source files
------------

// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// motor_pkg : shared types and op-to-side mapping for motor_drive_sequencer
// Revision  : 1.0 - initial release
// ============================================================================
package motor_pkg;

  typedef enum logic [2:0] {
    OP_STOP   = 3'd0,
    OP_FWD    = 3'd1,
    OP_REV    = 3'd2,
    OP_TURN_L = 3'd3,
    OP_TURN_R = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_COAST = 2'd2
  } state_e;

  // Bit order is {in1/in3, in2/in4} of one bridge half.
  typedef enum logic [1:0] {
    DIR_OFF = 2'b00,
    DIR_FWD = 2'b10,
    DIR_REV = 2'b01
  } dir_e;

  typedef struct packed {
    dir_e left;
    dir_e right;
  } side_pair_t;

  // Unknown op codes fall through to the all-off pair, i.e. behave as STOP.
  function automatic side_pair_t op_to_sides(input logic [2:0] op);
    side_pair_t s;
    s.left  = DIR_OFF;
    s.right = DIR_OFF;
    case (op)
      OP_FWD:    begin s.left = DIR_FWD; s.right = DIR_FWD; end
      OP_REV:    begin s.left = DIR_REV; s.right = DIR_REV; end
      OP_TURN_L: begin s.left = DIR_REV; s.right = DIR_FWD; end
      OP_TURN_R: begin s.left = DIR_FWD; s.right = DIR_REV; end
      default:   ;
    endcase
    return s;
  endfunction

  function automatic logic is_reversal(input dir_e cur, input dir_e nxt);
    return ((cur == DIR_FWD) && (nxt == DIR_REV)) ||
           ((cur == DIR_REV) && (nxt == DIR_FWD));
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_drive_sequencer_pwm.sv
`default_nettype none
// ============================================================================
// motor_pwm : free-running PWM counter with duty compare against shared speed
// Revision  : 1.0 - initial release
// ============================================================================
module motor_pwm
  import motor_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] speed,
  output logic                pwm_hit
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + PWM_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign pwm_hit = (cnt_q < speed);

endmodule
`default_nettype wire

// File: rtl/motor_drive_sequencer.sv
`default_nettype none
// ============================================================================
// motor_drive_sequencer : command sequencer driving two L298N H-bridges
// Revision              : 1.0 - initial release
// ============================================================================
module motor_drive_sequencer
  import motor_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 1000,
  parameter int DEAD_TICKS = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                e_stop,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [PWM_BITS-1:0] cmd_speed,
  input  logic [15:0]         cmd_duration,
  output logic                busy,
  output logic                done,
  output logic                drv1_motor_a_en,
  output logic                drv1_motor_b_en,
  output logic                drv2_motor_a_en,
  output logic                drv2_motor_b_en,
  output logic                drv1_motor_a_in1,
  output logic                drv1_motor_a_in2,
  output logic                drv1_motor_b_in3,
  output logic                drv1_motor_b_in4,
  output logic                drv2_motor_a_in1,
  output logic                drv2_motor_a_in2,
  output logic                drv2_motor_b_in3,
  output logic                drv2_motor_b_in4
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TICKS);

  state_e              state_q, state_d;
  dir_e                left_q, left_d, right_q, right_d;
  logic [PWM_BITS-1:0] speed_q, speed_d;
  logic [15:0]         dur_q, dur_d;
  logic                timed_q, timed_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [DEAD_W-1:0]   coast_q, coast_d;
  logic [7:0]          pins_q, pins_d;
  logic [3:0]          en_q, en_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [1:0]          exp_sr_q, exp_sr_d;
  logic                done_q, done_d;

  logic       w_tick, w_accept, w_new_stop, w_expire, w_expired, w_run, w_hit;
  side_pair_t w_new;

  motor_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .speed   (speed_q),
    .pwm_hit (w_hit)
  );

  assign w_tick     = (pre_q == PRE_LAST);
  assign w_accept   = cmd_valid && ready_q && !e_stop;
  assign w_new      = op_to_sides(cmd_op);
  assign w_new_stop = (w_new.left == DIR_OFF) || (cmd_speed == '0);
  assign w_expire   = w_tick && timed_q && (dur_q == 16'd1);

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    speed_d   = speed_q;
    dur_d     = dur_q;
    timed_d   = timed_q;
    coast_d   = coast_q;
    w_expired = 1'b0;
    pre_d     = w_tick ? '0 : pre_q + PRE_W'(1);
    if (timed_q && w_tick && (dur_q != 16'd0)) dur_d = dur_q - 16'd1;
    if ((state_q == ST_COAST) && w_tick) coast_d = coast_q - DEAD_W'(1);

    if (e_stop) begin
      state_d = ST_IDLE;
    end else if (w_accept) begin
      pre_d = '0;
      if (w_new_stop) begin
        state_d = ST_IDLE;
      end else begin
        left_d  = w_new.left;
        right_d = w_new.right;
        speed_d = cmd_speed;
        dur_d   = cmd_duration;
        timed_d = (cmd_duration != 16'd0);
        // The duration keeps counting through the coast, so it is measured from acceptance.
        if ((state_q == ST_RUN) &&
            (is_reversal(left_q, w_new.left) || is_reversal(right_q, w_new.right))) begin
          state_d = ST_COAST;
          coast_d = DEAD_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else if ((state_q != ST_IDLE) && w_expire) begin
      state_d   = ST_IDLE;
      w_expired = 1'b1;
    end else if ((state_q == ST_COAST) && w_tick && (coast_q == DEAD_W'(1))) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    w_run    = (state_q == ST_RUN);
    pins_d   = w_run ? {left_q, left_q, right_q, right_q} : 8'h00;
    en_d     = {4{w_run && w_hit}} &
               {(left_q != DIR_OFF), (left_q != DIR_OFF), (right_q != DIR_OFF), (right_q != DIR_OFF)};
    busy_d   = (state_q != ST_IDLE);
    ready_d  = (state_d != ST_COAST) && !e_stop;
    // Two stages so done lands one cycle after the pins have gone off.
    exp_sr_d = {exp_sr_q[0], w_expired};
    done_d   = exp_sr_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      left_q   <= DIR_OFF;
      right_q  <= DIR_OFF;
      speed_q  <= '0;
      dur_q    <= '0;
      timed_q  <= 1'b0;
      pre_q    <= '0;
      coast_q  <= '0;
      pins_q   <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      exp_sr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      speed_q  <= speed_d;
      dur_q    <= dur_d;
      timed_q  <= timed_d;
      pre_q    <= pre_d;
      coast_q  <= coast_d;
      pins_q   <= pins_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      exp_sr_q <= exp_sr_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready        = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign drv1_motor_a_en  = en_q[3];
  assign drv1_motor_b_en  = en_q[2];
  assign drv2_motor_a_en  = en_q[1];
  assign drv2_motor_b_en  = en_q[0];
  assign drv1_motor_a_in1 = pins_q[7];
  assign drv1_motor_a_in2 = pins_q[6];
  assign drv1_motor_b_in3 = pins_q[5];
  assign drv1_motor_b_in4 = pins_q[4];
  assign drv2_motor_a_in1 = pins_q[3];
  assign drv2_motor_a_in2 = pins_q[2];
  assign drv2_motor_b_in3 = pins_q[1];
  assign drv2_motor_b_in4 = pins_q[0];

endmodule
`default_nettype wire

// File: tb/tb_motor_drive_sequencer.sv
`default_nettype none
// ============================================================================
// tb_motor_drive_sequencer : vector table, directed sequences and random run
// Revision                 : 1.0 - initial release
// ============================================================================
module tb_motor_drive_sequencer;

  localparam int TD = 4;
  localparam int DT = 2;
  localparam longint INF = 64'sd1 << 60;

  logic clk, rst_n, e_stop, cmd_valid, cmd_ready, busy, done;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_speed;
  logic [15:0] cmd_duration;
  logic d1a_en, d1b_en, d2a_en, d2b_en;
  logic d1a_in1, d1a_in2, d1b_in3, d1b_in4, d2a_in1, d2a_in2, d2b_in3, d2b_in4;
  logic [7:0]  pins;
  logic [3:0]  ens;
  logic [14:0] obs;

  assign pins = {d1a_in1, d1a_in2, d1b_in3, d1b_in4, d2a_in1, d2a_in2, d2b_in3, d2b_in4};
  assign ens  = {d1a_en, d1b_en, d2a_en, d2b_en};
  assign obs  = {cmd_ready, busy, done, ens, pins};

  motor_drive_sequencer #(.PWM_BITS(8), .TICK_DIV(TD), .DEAD_TICKS(DT)) dut (
    .clk(clk), .rst_n(rst_n), .e_stop(e_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_speed(cmd_speed), .cmd_duration(cmd_duration),
    .busy(busy), .done(done),
    .drv1_motor_a_en(d1a_en), .drv1_motor_b_en(d1b_en),
    .drv2_motor_a_en(d2a_en), .drv2_motor_b_en(d2b_en),
    .drv1_motor_a_in1(d1a_in1), .drv1_motor_a_in2(d1a_in2),
    .drv1_motor_b_in3(d1b_in3), .drv1_motor_b_in4(d1b_in4),
    .drv2_motor_a_in1(d2a_in1), .drv2_motor_a_in2(d2a_in2),
    .drv2_motor_b_in3(d2b_in3), .drv2_motor_b_in4(d2b_in4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the live command as absolute edge times.
  longint k;                  // posedges since reset release
  bit     m_valid, m_ready;
  int     m_l, m_r, m_speed;  // sides: 0 off, 1 fwd, 2 rev
  longint m_on, m_off, m_done_at;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, k);
    end
  endtask

  task automatic model_reset();
    k = 0; m_valid = 0; m_ready = 1; m_l = 0; m_r = 0; m_speed = 0;
    m_on = 0; m_off = 0; m_done_at = -1;
  endtask

  function automatic void sides(input int op, output int l, output int r);
    case (op)
      1: begin l = 1; r = 1; end
      2: begin l = 2; r = 2; end
      3: begin l = 2; r = 1; end
      4: begin l = 1; r = 2; end
      default: begin l = 0; r = 0; end
    endcase
  endfunction

  function automatic logic [1:0] pp(input int d);
    return (d == 1) ? 2'b10 : ((d == 2) ? 2'b01 : 2'b00);
  endfunction

  function automatic bit opposite(input int a, input int b);
    return ((a == 1) && (b == 2)) || ((a == 2) && (b == 1));
  endfunction

  // One clock: predict, advance the model, clock, compare; returns at the negedge.
  task automatic cyc();
    longint e = k + 1;
    bit live, run, hit, expire, rev;
    int l, r;
    logic [7:0]  pe;
    logic [3:0]  ee;
    logic [14:0] want;
    live = m_valid && (k < m_off);
    run  = live && (m_on <= k);
    hit  = (k % 256) < m_speed;
    pe   = run ? {pp(m_l), pp(m_l), pp(m_r), pp(m_r)} : 8'h00;
    ee   = (run && hit) ? 4'hF : 4'h0;
    expire = m_valid && (e == m_off);
    if (e_stop) begin
      m_valid = 0;
    end else if (cmd_valid && m_ready) begin
      sides(int'(cmd_op), l, r);
      if ((l == 0) || (cmd_speed == 0)) begin
        m_valid = 0;
      end else begin
        rev = run && (opposite(m_l, l) || opposite(m_r, r));
        m_valid = 1; m_l = l; m_r = r; m_speed = int'(cmd_speed);
        m_on  = e + (rev ? DT * TD : 0);
        m_off = (cmd_duration == 0) ? INF : e + longint'(cmd_duration) * TD;
      end
    end else if (expire) begin
      m_valid = 0;
      m_done_at = e + 2;
    end
    m_ready = !(m_valid && (e < m_on) && (e < m_off)) && !e_stop;
    want = {m_ready, live, (e == m_done_at), ee, pe};
    @(posedge clk);
    k = e;
    #1;
    check("cycle", obs, want);
    @(negedge clk);
  endtask

  task automatic send(input int op, input int spd, input int dur);
    cmd_valid = 1; cmd_op = 3'(op); cmd_speed = 8'(spd); cmd_duration = 16'(dur);
    cyc();
    cmd_valid = 0;
  endtask

  typedef struct { int op; int spd; logic [7:0] pins; logic busy; } vec_t;
  vec_t tbl[9];

  int act, dn, lo, enc;

  initial begin
    tbl[0] = '{1, 100, 8'hAA, 1'b1};
    tbl[1] = '{2, 100, 8'h55, 1'b1};
    tbl[2] = '{3,  50, 8'h5A, 1'b1};
    tbl[3] = '{4,  50, 8'hA5, 1'b1};
    tbl[4] = '{0, 200, 8'h00, 1'b0};
    tbl[5] = '{6, 200, 8'h00, 1'b0};
    tbl[6] = '{7, 200, 8'h00, 1'b0};
    tbl[7] = '{1,   0, 8'h00, 1'b0};
    tbl[8] = '{5,  90, 8'h00, 1'b0};

    rst_n = 0; e_stop = 0; cmd_valid = 0; cmd_op = 0; cmd_speed = 0; cmd_duration = 0;
    model_reset();
    #12;
    check("reset", obs, 15'h4000);
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].op, tbl[i].spd, 0);
      cyc();
      check("tbl_pins", pins, tbl[i].pins);
      check("tbl_busy", busy, tbl[i].busy);
      send(0, 0, 0);
      cyc();
    end

    // Timed FWD: 12 active clocks, then one done pulse.
    send(1, 128, 3);
    act = 0; dn = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pins == 8'hAA) act++;
      if (done) dn++;
    end
    check("fwd_len", act, 12);
    check("fwd_done", dn, 1);
    check("fwd_busy", busy, 0);

    // Reversal: coast with ready low, then REV until 20 ticks after acceptance.
    send(1, 100, 0);
    repeat (3) cyc();
    send(2, 150, 20);
    lo = (cmd_ready == 0) ? 1 : 0; act = 0; dn = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!cmd_ready) lo++;
      if (pins == 8'h55) act++;
      if (done) dn++;
    end
    check("coast_ready", lo, 8);
    check("rev_len", act, 72);
    check("rev_done", dn, 1);

    // Same-direction preemption restarts the duration without a coast.
    send(1, 100, 3);
    repeat (8) cyc();
    send(1, 255, 3);
    lo = 0; act = 0; dn = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (!cmd_ready) lo++;
      if (pins == 8'hAA) act++;
      if (done) dn++;
    end
    check("pre_noco", lo, 0);
    check("pre_len", act, 12);
    check("pre_done", dn, 1);
    send(1, 255, 0);
    cyc();
    enc = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (d1a_en) enc++;
    end
    check("duty255", enc, 255);
    send(0, 0, 0);
    cyc();

    // Untimed TURN_L holds indefinitely; STOP clears it one clock later.
    send(3, 64, 0);
    cyc();
    check("turnl_pins", pins, 8'h5A);
    enc = 0; dn = 0;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (i < 256 && d2b_en) enc++;
      if (done) dn++;
    end
    check("turnl_duty", enc, 64);
    check("turnl_nodone", dn, 0);
    send(0, 0, 0);
    cyc();
    check("stop_off", {ens, pins}, 12'h000);

    // e_stop during coast alongside a command.
    send(1, 100, 0);
    repeat (3) cyc();
    send(2, 100, 0);
    cyc();
    e_stop = 1; cmd_valid = 1; cmd_op = 3'd1; cmd_speed = 8'd100; cmd_duration = 16'd0;
    cyc();
    cmd_valid = 0;
    cyc();
    check("estop_idle", busy, 0);
    e_stop = 0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done) dn++;
    end
    check("estop_ready", cmd_ready, 1);
    check("estop_nodone", dn, 0);
    check("estop_pins", pins, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      e_stop    = ($urandom_range(0, 99) < 2);
      cmd_valid = ($urandom_range(0, 19) == 0);
      cmd_op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       cmd_speed = 8'd0;
        1:       cmd_speed = 8'd255;
        default: cmd_speed = 8'($urandom_range(1, 254));
      endcase
      cmd_duration = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      cyc();
    end
    e_stop = 0; cmd_valid = 0;
    repeat (2) cyc();

    // Asynchronous reset while driving.
    send(1, 200, 0);
    repeat (5) cyc();
    #2 rst_n = 0;
    #1 check("async_reset", obs, 15'h4000);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (5) cyc();
    send(1, 128, 2);
    repeat (15) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
